strand_decoder: RTL and testbench
=================================

# strand_decoder

Receive-side counterpart to the LED strand driver. It samples a single-wire WS2812-style NRZ line, measures each high pulse, and reconstructs 24-bit GRB pixels. It presents each pixel as RGB with an index and reports frame latch and protocol errors. Used for loopback checking of the driver's output (driver strand pin wired back into a PMOD input) and as the front end of a daisy-chain/repeater design.

## Interface
Parameters:
- NUM_LEDS, 30: maximum pixels per frame that are reported.
- MIN_HIGH, 20: minimum legal high-pulse width in cycles; shorter pulses are glitches.
- BIT_THRESHOLD, 60: high width of at least this many cycles decodes as 1, otherwise 0.
- MAX_HIGH, 100: high width above this many cycles is an error.
- RESET_CYCLES, 5000: low time in cycles that constitutes a latch (50 µs at 100 MHz).

Ports:
- clk_in, input, 1: system clock, 100 MHz.
- rst_in, input, 1: asynchronous, active-high reset.
- strand_in, input, 1: raw asynchronous strand line.
- red_out, output, 8: decoded red of the last pixel.
- green_out, output, 8: decoded green.
- blue_out, output, 8: decoded blue.
- pixel_index, output, $clog2(NUM_LEDS): position of the pixel in the frame, 0-based.
- pixel_valid, output, 1: one-cycle pulse when the colour outputs and pixel_index are new.
- frame_done, output, 1: one-cycle pulse on latch.
- frame_overflow, output, 1: qualifies frame_done; high if the frame held more than NUM_LEDS pixels.
- pulse_error, output, 1: one-cycle pulse on a glitch, an overlong high, or a partial pixel at latch.

## Operation
- strand_in passes through a 2-FF synchronizer to give strand_s; all decoding uses strand_s.
- The state machine has three states: SYNC, LOW and HIGH.
- SYNC (entered on reset and after any error):
  - lo_cnt counts consecutive low cycles.
  - A high sample clears lo_cnt.
  - When lo_cnt reaches RESET_CYCLES, go to LOW with bit_cnt=0 and pix_cnt=0. No frame_done is issued.
- LOW:
  - lo_cnt counts low cycles and saturates at RESET_CYCLES.
  - strand_s=1 moves to HIGH with hi_cnt=1.
  - If lo_cnt reaches RESET_CYCLES and at least one bit has arrived since the last latch, pulse frame_done.
    - frame_overflow = (pix_cnt > NUM_LEDS).
    - If bit_cnt≠0, also pulse pulse_error and discard the partial pixel.
    - Then clear bit_cnt and pix_cnt.
- HIGH:
  - hi_cnt increments each cycle.
  - hi_cnt > MAX_HIGH pulses pulse_error and moves to SYNC.
  - On strand_s=0:
    - hi_cnt < MIN_HIGH pulses pulse_error and moves to SYNC.
    - Otherwise shift bit (hi_cnt ≥ BIT_THRESHOLD) into a 24-bit shift register MSB-first, increment bit_cnt, clear lo_cnt (set to 1) and go to LOW.
- Bit order on the wire is G[7:0], R[7:0], B[7:0].
- On the 24th bit:
  - If pix_cnt < NUM_LEDS, load red/green/blue_out, set pixel_index=pix_cnt and pulse pixel_valid.
  - Otherwise emit no pixel_valid.
  - In both cases pix_cnt increments (saturating at NUM_LEDS+1) and bit_cnt returns to 0.
- Colour outputs and pixel_index hold their value until the next pixel_valid.
- Counter widths: lo_cnt is $clog2(RESET_CYCLES+1) bits; hi_cnt is $clog2(MAX_HIGH+2) bits. Both saturate and never wrap.

## Timing
- Every output resets to 0, and the state resets to SYNC.
- Synchronizer latency is 2 cycles from strand_in to strand_s.
- pixel_valid is registered. It asserts the cycle after the first clock at which strand_s=0 ends the 24th high pulse, 3 cycles after the raw falling edge.
- frame_done asserts the cycle after lo_cnt reaches RESET_CYCLES, i.e. RESET_CYCLES+1 cycles after the synchronized falling edge.
- pixel_valid and frame_done never coincide, because latch requires a full low period.
- pulse_error may coincide with frame_done (partial pixel case).
- There is no backpressure: the consumer must accept pixel_valid when it pulses.
- rst_in asserted mid-frame clears everything immediately. Decoding resumes only after a full RESET_CYCLES low period.

## Structure
- Package strand_pkg holds:
  - the state enum (SYNC, LOW, HIGH);
  - the default timing constants (T0H=40, T1H=80, TBIT=125, TLATCH=5000 at 100 MHz), shared with the led driver;
  - a pixel struct {g, r, b} of 8 bits each.
- Sub-module sync_2ff is the generic 2-flop synchronizer, with asynchronous reset to 0.

## Test plan
- Single pixel: after a 5000-cycle low, send G=0x12, R=0xA5, B=0x3C with 0-bits as 40 high/85 low and 1-bits as 80 high/45 low, then a 6000-cycle low.
  - Expect one pixel_valid with red_out=A5, green_out=12, blue_out=3C, pixel_index=0.
  - Then frame_done with frame_overflow=0 and no pulse_error.
- Full frame: 30 pixels, each value = index×8.
  - Expect 30 pixel_valid pulses with indices 0–29 in order and matching data, then one frame_done.
- Overflow: 32 pixels.
  - Expect 30 pixel_valid pulses, then frame_done with frame_overflow=1.
- Errors:
  - A 10-cycle high pulse gives pulse_error and no pixel.
  - A 150-cycle high gives pulse_error at cycle 102 after the synchronized rise.
  - A frame of 12 bits then latch gives frame_done with pulse_error.
- Reset: assert rst_in after bit 10 of a pixel, release, then send a full pixel without a preceding latch low. Expect no pixel_valid.
- Loopback: drive the led driver with sw=0xF81F into this block.
  - Expect red_out=F8, green_out=00, blue_out=F8 for all 30 indices, every frame.

Source files
------------

// File: rtl/strand_pkg.sv
// Shared types and default NRZ timing for the LED strand driver and decoder.
// All timing constants are in 100 MHz clock cycles.
package strand_pkg;

   typedef enum logic [1:0] {
      SYNC,
      LOW,
      HIGH
   } state_e;

   localparam int T0H    = 40;
   localparam int T1H    = 80;
   localparam int TBIT   = 125;
   localparam int TLATCH = 5000;

   // Field order matches wire order: green is shifted in first.
   typedef struct packed {
      logic [7:0] g;
      logic [7:0] r;
      logic [7:0] b;
   } pixel_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous single-bit or bus inputs.
// Both stages clear asynchronously to 0.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= '0;
         q_o    <= '0;
      end else begin
         // NOTE: non-blocking keeps these as two distinct flop stages.
         meta_q <= d_i;
         q_o    <= meta_q;
      end
   end

endmodule

// File: rtl/strand_decoder.sv
// Samples a WS2812-style NRZ strand, measures high-pulse widths and rebuilds
// GRB pixels, reporting them as RGB with an index, plus latch and error pulses.
module strand_decoder
   import strand_pkg::*;
#(
   parameter int NUM_LEDS      = 30,
   parameter int MIN_HIGH      = 20,
   parameter int BIT_THRESHOLD = (T0H + T1H) / 2,
   parameter int MAX_HIGH      = 100,
   parameter int RESET_CYCLES  = TLATCH
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   input  logic                        strand_in,
   output logic [7:0]                  red_out,
   output logic [7:0]                  green_out,
   output logic [7:0]                  blue_out,
   output logic [$clog2(NUM_LEDS)-1:0] pixel_index,
   output logic                        pixel_valid,
   output logic                        frame_done,
   output logic                        frame_overflow,
   output logic                        pulse_error
);

   localparam int LO_W  = $clog2(RESET_CYCLES + 1);
   localparam int HI_W  = $clog2(MAX_HIGH + 2);
   localparam int PIX_W = $clog2(NUM_LEDS + 2);
   localparam int IDX_W = $clog2(NUM_LEDS);

   localparam logic [LO_W-1:0]  LO_LATCH = LO_W'(RESET_CYCLES);
   localparam logic [HI_W-1:0]  HI_MIN   = HI_W'(MIN_HIGH);
   localparam logic [HI_W-1:0]  HI_ONE   = HI_W'(BIT_THRESHOLD);
   localparam logic [HI_W-1:0]  HI_MAX   = HI_W'(MAX_HIGH);
   localparam logic [HI_W-1:0]  HI_SAT   = HI_W'(MAX_HIGH + 1);
   localparam logic [PIX_W-1:0] PIX_LIM  = PIX_W'(NUM_LEDS);
   localparam logic [PIX_W-1:0] PIX_SAT  = PIX_W'(NUM_LEDS + 1);

   logic              strand_s;
   state_e            state_q;
   logic [LO_W-1:0]   lo_cnt_q;
   logic [HI_W-1:0]   hi_cnt_q;
   logic [4:0]        bit_cnt_q;
   logic [PIX_W-1:0]  pix_cnt_q;
   logic [22:0]       shift_q;
   logic              got_bit_q;

   logic              bit_val;
   logic [23:0]       shift_d;
   pixel_t            pix_d;
   logic [PIX_W-1:0]  pix_cnt_d;
   logic [LO_W-1:0]   lo_cnt_d;
   logic [HI_W-1:0]   hi_cnt_d;

   sync_2ff #(.WIDTH(1)) u_sync (
      .clk_i (clk_in),
      .rst_i (rst_in),
      .d_i   (strand_in),
      .q_o   (strand_s)
   );

   assign bit_val   = (hi_cnt_q >= HI_ONE);
   assign shift_d   = {shift_q, bit_val};
   assign pix_d     = pixel_t'(shift_d);
   assign pix_cnt_d = (pix_cnt_q == PIX_SAT)  ? pix_cnt_q : pix_cnt_q + 1'b1;
   assign lo_cnt_d  = (lo_cnt_q  == LO_LATCH) ? lo_cnt_q  : lo_cnt_q + 1'b1;
   assign hi_cnt_d  = (hi_cnt_q  == HI_SAT)   ? hi_cnt_q  : hi_cnt_q + 1'b1;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q        <= SYNC;
         lo_cnt_q       <= '0;
         hi_cnt_q       <= '0;
         bit_cnt_q      <= '0;
         pix_cnt_q      <= '0;
         shift_q        <= '0;
         got_bit_q      <= 1'b0;
         red_out        <= '0;
         green_out      <= '0;
         blue_out       <= '0;
         pixel_index    <= '0;
         pixel_valid    <= 1'b0;
         frame_done     <= 1'b0;
         frame_overflow <= 1'b0;
         pulse_error    <= 1'b0;
      end else begin
         // NOTE: pulse outputs default low every cycle; branches only raise them.
         pixel_valid    <= 1'b0;
         frame_done     <= 1'b0;
         frame_overflow <= 1'b0;
         pulse_error    <= 1'b0;

         case (state_q)
            SYNC: begin
               if (strand_s) begin
                  lo_cnt_q <= '0;
               end else if (lo_cnt_q >= LO_LATCH - 1'b1) begin
                  state_q   <= LOW;
                  lo_cnt_q  <= LO_LATCH;
                  bit_cnt_q <= '0;
                  pix_cnt_q <= '0;
                  got_bit_q <= 1'b0;
               end else begin
                  lo_cnt_q <= lo_cnt_q + 1'b1;
               end
            end

            LOW: begin
               // A frame is only closed if something arrived since the last latch.
               if (lo_cnt_q == LO_LATCH && got_bit_q) begin
                  frame_done     <= 1'b1;
                  frame_overflow <= (pix_cnt_q > PIX_LIM);
                  pulse_error    <= (bit_cnt_q != '0);
                  bit_cnt_q      <= '0;
                  pix_cnt_q      <= '0;
                  got_bit_q      <= 1'b0;
               end
               if (strand_s) begin
                  state_q  <= HIGH;
                  hi_cnt_q <= HI_W'(1);
               end else begin
                  lo_cnt_q <= lo_cnt_d;
               end
            end

            HIGH: begin
               if (hi_cnt_q > HI_MAX) begin
                  pulse_error <= 1'b1;
                  state_q     <= SYNC;
                  lo_cnt_q    <= '0;
               end else if (strand_s) begin
                  hi_cnt_q <= hi_cnt_d;
               end else if (hi_cnt_q < HI_MIN) begin
                  pulse_error <= 1'b1;
                  state_q     <= SYNC;
                  lo_cnt_q    <= '0;
               end else begin
                  shift_q   <= shift_d[22:0];
                  got_bit_q <= 1'b1;
                  lo_cnt_q  <= LO_W'(1);
                  state_q   <= LOW;
                  if (bit_cnt_q == 5'd23) begin
                     bit_cnt_q <= '0;
                     pix_cnt_q <= pix_cnt_d;
                     if (pix_cnt_q < PIX_LIM) begin
                        red_out     <= pix_d.r;
                        green_out   <= pix_d.g;
                        blue_out    <= pix_d.b;
                        pixel_index <= pix_cnt_q[IDX_W-1:0];
                        pixel_valid <= 1'b1;
                     end
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
               end
            end

            default: state_q <= SYNC;
         endcase
      end
   end

endmodule

// File: tb/tb_strand_decoder.sv
// Scoreboard bench for strand_decoder: stimulus pushes expected events, a
// monitor pops and compares them whenever the decoder reports something.
`timescale 1ns/1ps
module tb_strand_decoder;
   import strand_pkg::*;

   // Package timing divided by 8 so multi-frame traffic stays short.
   localparam int SCALE = 8;
   localparam int NL    = 30;
   localparam int MINH  = 3;
   localparam int THR   = 8;
   localparam int MAXH  = 12;
   localparam int RST   = TLATCH / SCALE;
   localparam int T0    = T0H / SCALE;
   localparam int T1    = T1H / SCALE;
   localparam int TB    = TBIT / SCALE;
   localparam int LATCH = RST + 100;

   localparam logic [1:0] EV_PIX = 2'd1, EV_FRAME = 2'd2, EV_ERR = 2'd3;

   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      logic [4:0] idx;
      logic       ovf;
      logic       err;
   } ev_t;

   logic       clk_in = 1'b0;
   logic       rst_in;
   logic       strand_in;
   logic [7:0] red_out, green_out, blue_out;
   logic [4:0] pixel_index;
   logic       pixel_valid, frame_done, frame_overflow, pulse_error;

   ev_t exp_q[$];
   int  n_tests  = 0;
   int  n_fail   = 0;
   int  cyc      = 0;
   int  fall_cyc = 0;
   int  rise_cyc = 0;
   int  done_cyc = -1;
   int  err_cyc  = -1;

   strand_decoder #(
      .NUM_LEDS      (NL),
      .MIN_HIGH      (MINH),
      .BIT_THRESHOLD (THR),
      .MAX_HIGH      (MAXH),
      .RESET_CYCLES  (RST)
   ) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .strand_in      (strand_in),
      .red_out        (red_out),
      .green_out      (green_out),
      .blue_out       (blue_out),
      .pixel_index    (pixel_index),
      .pixel_valid    (pixel_valid),
      .frame_done     (frame_done),
      .frame_overflow (frame_overflow),
      .pulse_error    (pulse_error)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic compare(input string name, input ev_t obs);
      ev_t e;
      if (exp_q.size() == 0) begin
         check({"unexpected_", name}, {31'd0, obs}, 64'd0);
      end else begin
         e = exp_q.pop_front();
         check(name, {31'd0, obs}, {31'd0, e});
      end
   endtask

   // Monitor: samples 1 ns after each rising edge.
   always @(posedge clk_in) begin
      ev_t obs;
      cyc = cyc + 1;
      #1;
      if (!rst_in) begin
         if (pixel_valid) begin
            obs = '{kind: EV_PIX, r: red_out, g: green_out, b: blue_out,
                    idx: pixel_index, ovf: 1'b0, err: 1'b0};
            compare("pixel", obs);
         end
         if (frame_done) begin
            done_cyc = cyc;
            obs = '{kind: EV_FRAME, r: 8'd0, g: 8'd0, b: 8'd0, idx: 5'd0,
                    ovf: frame_overflow, err: pulse_error};
            compare("frame", obs);
         end else if (pulse_error) begin
            err_cyc = cyc;
            obs = '{kind: EV_ERR, r: 8'd0, g: 8'd0, b: 8'd0, idx: 5'd0,
                    ovf: 1'b0, err: 1'b1};
            compare("error", obs);
         end
      end
   end

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   task automatic send_bit(input logic b);
      int th;
      th = b ? T1 : T0;
      strand_in = 1'b1;
      wait_n(th);
      strand_in = 1'b0;
      fall_cyc  = cyc;
      wait_n(TB - th);
   endtask

   task automatic send_word(input logic [23:0] w, input int nbits);
      for (int i = 23; i > 23 - nbits; i--) send_bit(w[i]);
   endtask

   task automatic send_pix(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
      send_word({g, r, b}, 24);
   endtask

   task automatic push_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                           input int idx);
      exp_q.push_back('{kind: EV_PIX, r: r, g: g, b: b, idx: 5'(idx), ovf: 1'b0, err: 1'b0});
   endtask

   task automatic push_frame(input logic ovf, input logic err);
      exp_q.push_back('{kind: EV_FRAME, r: 8'd0, g: 8'd0, b: 8'd0, idx: 5'd0, ovf: ovf, err: err});
   endtask

   task automatic push_err();
      exp_q.push_back('{kind: EV_ERR, r: 8'd0, g: 8'd0, b: 8'd0, idx: 5'd0, ovf: 1'b0, err: 1'b1});
   endtask

   function automatic logic [63:0] all_outputs();
      return {35'd0, red_out, green_out, blue_out, pixel_index,
              pixel_valid, frame_done, frame_overflow, pulse_error};
   endfunction

   initial begin
      logic [7:0]  v;
      logic [15:0] sw;

      strand_in = 1'b0;
      rst_in    = 1'b1;
      wait_n(3);
      check("reset_outputs", all_outputs(), 64'd0);
      rst_in = 1'b0;
      wait_n(LATCH);

      // Single pixel, then latch latency from the last raw falling edge.
      push_pix(8'hA5, 8'h12, 8'h3C, 0);
      push_frame(1'b0, 1'b0);
      send_pix(8'h12, 8'hA5, 8'h3C);
      wait_n(LATCH);
      check("latch_latency", 64'(done_cyc - fall_cyc), 64'(RST + 3));

      // Full frame.
      for (int i = 0; i < NL; i++) begin
         v = 8'(i * 8);
         push_pix(v, v, v, i);
         send_pix(v, v, v);
      end
      push_frame(1'b0, 1'b0);
      wait_n(LATCH);

      // Overflow: two extra pixels produce no pixel_valid.
      for (int i = 0; i < NL + 2; i++) begin
         v = 8'(i * 8);
         if (i < NL) push_pix(v, v, v, i);
         send_pix(v, v, v);
      end
      push_frame(1'b1, 1'b0);
      wait_n(LATCH);

      // Glitch shorter than MIN_HIGH.
      push_err();
      strand_in = 1'b1;
      wait_n(2);
      strand_in = 1'b0;
      wait_n(LATCH);

      // Overlong high.
      push_err();
      strand_in = 1'b1;
      rise_cyc  = cyc;
      wait_n(20);
      strand_in = 1'b0;
      wait_n(LATCH);
      check("overlong_latency", 64'(err_cyc - rise_cyc), 64'(MAXH + 4));

      // Partial pixel at latch.
      push_frame(1'b0, 1'b1);
      send_word(24'hABCDEF, 12);
      wait_n(LATCH);

      // Reset mid-pixel; the following pixel lacks a latch low and must be ignored.
      send_word(24'h5A5A5A, 10);
      rst_in    = 1'b1;
      strand_in = 1'b0;
      wait_n(3);
      check("midframe_reset_clears", all_outputs(), 64'd0);
      rst_in = 1'b0;
      send_pix(8'hFF, 8'hFF, 8'hFF);
      wait_n(LATCH);

      // Loopback: emulate the driver expanding RGB565 switches to GRB.
      sw = 16'hF81F;
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < NL; i++) begin
            push_pix(8'hF8, 8'h00, 8'hF8, i);
            send_pix({sw[10:5], 2'b00}, {sw[15:11], 3'b000}, {sw[4:0], 3'b000});
         end
         push_frame(1'b0, 1'b0);
         wait_n(LATCH);
      end

      wait_n(20);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
